// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read, write-back, issue and flush bus of the register file.
interface reg_file_sb_if #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int NUM_READ = 2
);
  localparam int AW = $clog2(NUM_REGS);
  logic [NUM_READ*AW-1:0]   rd_addr;
  logic [NUM_READ*XLEN-1:0] rd_data;
  logic [NUM_READ-1:0]      rd_busy;
  logic                     wb_en;
  logic [AW-1:0]            wb_addr;
  logic [XLEN-1:0]          wb_data;
  logic                     issue_en;
  logic [AW-1:0]            issue_addr;
  logic                     flush;
  logic [AW:0]              busy_count;
  modport master (
    output rd_addr, wb_en, wb_addr, wb_data, issue_en, issue_addr, flush,
    input  rd_data, rd_busy, busy_count
  );
  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data, issue_en, issue_addr, flush,
    output rd_data, rd_busy, busy_count
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with write-back bypass and busy scoreboard.
module reg_file_sb #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int NUM_READ = 2,
  parameter int BYPASS   = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  reg_file_sb_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = AW + 1;
  logic [XLEN-1:0]          mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_q, busy_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_READ*XLEN-1:0] rd_data;
  logic [NUM_READ-1:0]      rd_busy;
  logic [AW-1:0]            ra;
  logic                     byp;
  // flush, then write-back release, then issue reservation; the later step wins
  always_comb begin
    busy_d = bus.flush ? '0 : busy_q;
    if (bus.wb_en) busy_d[bus.wb_addr] = 1'b0;
    if (bus.issue_en) busy_d[bus.issue_addr] = 1'b1;
    busy_d[0] = 1'b0;
    cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_d = cnt_d + CW'(busy_d[i]);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (bus.wb_en && bus.wb_addr != '0) mem_q[bus.wb_addr] <= bus.wb_data;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  // outputs are forced to zero while reset is held, even on the bypass path
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra = '0;
    byp = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      byp = (BYPASS != 0) && bus.wb_en && bus.wb_addr == ra;
      rd_data[i*XLEN +: XLEN] = (!reset_n || ra == '0) ? '0 : byp ? bus.wb_data : mem_q[ra];
      rd_busy[i] = reset_n && ra != '0 && !byp && busy_q[ra];
    end
  end
  assign bus.rd_data    = rd_data;
  assign bus.rd_busy    = rd_busy;
  assign bus.busy_count = cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: random and directed stimulus against an array-based model,
// with bypassing and non-bypassing instances sharing the same inputs.
module tb_reg_file_sb;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  logic [31:0] m_mem [32];
  bit m_busy [32];

  always #5 clock = ~clock;

  reg_file_sb_if #(.NUM_REGS(32), .XLEN(32), .NUM_READ(2)) bus ();
  reg_file_sb_if #(.NUM_REGS(32), .XLEN(32), .NUM_READ(2)) bus0 ();

  assign bus0.rd_addr    = bus.rd_addr;
  assign bus0.wb_en      = bus.wb_en;
  assign bus0.wb_addr    = bus.wb_addr;
  assign bus0.wb_data    = bus.wb_data;
  assign bus0.issue_en   = bus.issue_en;
  assign bus0.issue_addr = bus.issue_addr;
  assign bus0.flush      = bus.flush;

  reg_file_sb #(.NUM_REGS(32), .XLEN(32), .NUM_READ(2), .BYPASS(1)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));
  reg_file_sb #(.NUM_REGS(32), .XLEN(32), .NUM_READ(2), .BYPASS(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(bus0));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_data(input int a, input bit b);
    if (!reset_n || a == 0) return 32'h0;
    if (b && bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
    return m_mem[a];
  endfunction

  function automatic logic m_rbusy(input int a, input bit b);
    if (!reset_n || a == 0) return 1'b0;
    if (b && bus.wb_en && int'(bus.wb_addr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  always @(negedge reset_n)
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end

  always @(posedge clock)
    if (reset_n) begin
      if (bus.flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      if (bus.wb_en && bus.wb_addr != 0) begin
        m_mem[bus.wb_addr] = bus.wb_data;
        m_busy[bus.wb_addr] = 1'b0;
      end
      if (bus.issue_en && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
    end

  always @(negedge clock)
    if (chk_on) begin
      for (int p = 0; p < 2; p++) begin
        int a;
        a = int'(bus.rd_addr[p*5 +: 5]);
        chk("model_data_byp", bus.rd_data[p*32 +: 32], m_data(a, 1'b1));
        chk("model_busy_byp", 32'(bus.rd_busy[p]), 32'(m_rbusy(a, 1'b1)));
        chk("model_data_nobyp", bus0.rd_data[p*32 +: 32], m_data(a, 1'b0));
        chk("model_busy_nobyp", 32'(bus0.rd_busy[p]), 32'(m_rbusy(a, 1'b0)));
      end
      chk("model_count", 32'(bus.busy_count), (reset_n ? m_count() : 0));
      chk("model_count_nobyp", 32'(bus0.busy_count), (reset_n ? m_count() : 0));
    end

  task automatic idle();
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.issue_en = 0; bus.issue_addr = 0; bus.flush = 0;
  endtask

  task automatic nxt();
    @(posedge clock); #1;
    idle();
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
    idle();
    bus.rd_addr = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    chk_on = 1'b1;
    for (int i = 1; i < 32; i++) begin
      nxt();
      bus.rd_addr = {5'(i), 5'(i)};
      @(negedge clock);
      chk("reset_rd0", bus.rd_data[31:0], 0);
      chk("reset_rd1", bus.rd_data[63:32], 0);
      chk("reset_busy", 32'(bus.rd_busy), 0);
      chk("reset_count", 32'(bus.busy_count), 0);
    end
    nxt();
    bus.wb_en = 1; bus.wb_addr = 5; bus.wb_data = 32'hDEADBEEF; bus.rd_addr = {5'd0, 5'd5};
    @(negedge clock);
    chk("bypass_data", bus.rd_data[31:0], 32'hDEADBEEF);
    chk("bypass_busy", 32'(bus.rd_busy[0]), 0);
    chk("nobypass_old", bus0.rd_data[31:0], 0);
    nxt();
    @(negedge clock);
    chk("after_wb_byp", bus.rd_data[31:0], 32'hDEADBEEF);
    chk("after_wb_nobyp", bus0.rd_data[31:0], 32'hDEADBEEF);
    nxt();
    bus.wb_en = 1; bus.wb_addr = 0; bus.wb_data = 32'h12345678;
    bus.issue_en = 1; bus.issue_addr = 0; bus.rd_addr = {5'd0, 5'd0};
    @(negedge clock);
    chk("x0_data", bus.rd_data[31:0], 0);
    chk("x0_busy", 32'(bus.rd_busy[0]), 0);
    nxt();
    @(negedge clock);
    chk("x0_count", 32'(bus.busy_count), 0);
    chk("x0_data_after", bus.rd_data[31:0], 0);
    nxt();
    bus.issue_en = 1; bus.issue_addr = 7;
    nxt();
    bus.rd_addr = {5'd0, 5'd7};
    @(negedge clock);
    chk("x7_busy", 32'(bus.rd_busy[0]), 1);
    chk("x7_count", 32'(bus.busy_count), 1);
    nxt();
    bus.issue_en = 1; bus.issue_addr = 7; bus.wb_en = 1; bus.wb_addr = 7; bus.wb_data = 32'hA5;
    nxt();
    @(negedge clock);
    chk("x7_reissue_data", bus.rd_data[31:0], 32'hA5);
    chk("x7_reissue_busy", 32'(bus.rd_busy[0]), 1);
    chk("x7_reissue_count", 32'(bus.busy_count), 1);
    nxt();
    bus.wb_en = 1; bus.wb_addr = 7; bus.wb_data = 32'h5A;
    nxt();
    @(negedge clock);
    chk("x7_release_data", bus.rd_data[31:0], 32'h5A);
    chk("x7_release_busy", 32'(bus.rd_busy[0]), 0);
    chk("x7_release_count", 32'(bus.busy_count), 0);
    nxt(); bus.issue_en = 1; bus.issue_addr = 3;
    nxt(); bus.issue_en = 1; bus.issue_addr = 4;
    nxt(); bus.issue_en = 1; bus.issue_addr = 9;
    nxt();
    @(negedge clock);
    chk("three_issued", 32'(bus.busy_count), 3);
    nxt();
    bus.flush = 1; bus.issue_en = 1; bus.issue_addr = 12;
    bus.wb_en = 1; bus.wb_addr = 4; bus.wb_data = 32'h77;
    nxt();
    bus.rd_addr = {5'd12, 5'd4};
    @(negedge clock);
    chk("flush_count", 32'(bus.busy_count), 1);
    chk("flush_x4_data", bus.rd_data[31:0], 32'h77);
    chk("flush_x4_busy", 32'(bus.rd_busy[0]), 0);
    chk("flush_x12_busy", 32'(bus.rd_busy[1]), 1);
    nxt();
    bus.rd_addr = {5'd9, 5'd3};
    @(negedge clock);
    chk("flush_x3x9_busy", 32'(bus.rd_busy), 0);
    for (int c = 0; c < 400; c++) begin
      nxt();
      bus.wb_en = 1'($urandom_range(0, 1));
      bus.wb_addr = raddr();
      bus.wb_data = $urandom();
      bus.issue_en = 1'($urandom_range(0, 1));
      bus.issue_addr = raddr();
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.rd_addr = {raddr(), raddr()};
    end
    nxt();
    bus.issue_en = 1; bus.issue_addr = 7; bus.wb_en = 1; bus.wb_addr = 6; bus.wb_data = 32'hCAFE0006;
    nxt();
    bus.wb_en = 1; bus.wb_addr = 6; bus.wb_data = 32'h0BAD0BAD; bus.rd_addr = {5'd7, 5'd6};
    #2;
    chk("pre_reset_data", bus.rd_data[31:0], 32'h0BAD0BAD);
    chk("pre_reset_busy7", 32'(bus.rd_busy[1]), 1);
    reset_n = 1'b0;
    #1;
    chk("async_data0", bus.rd_data[31:0], 0);
    chk("async_data1", bus.rd_data[63:32], 0);
    chk("async_busy", 32'(bus.rd_busy), 0);
    chk("async_count", 32'(bus.busy_count), 0);
    chk("async_count_nobyp", 32'(bus0.busy_count), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle();
    @(negedge clock);
    chk("post_reset_x6", bus.rd_data[31:0], 0);
    chk("post_reset_x7", bus.rd_data[63:32], 0);
    chk("post_reset_count", 32'(bus.busy_count), 0);
    nxt();
    @(negedge clock);
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
